// File: rtl/player_ctrl.sv
// Player movement controller: turns held direction keys into a clamped sprite position
// and a walk-animation frame, advancing once per movement tick while a stage is active.
module player_ctrl #(
  parameter int unsigned MOVE_DIV = 1_250_000,
  parameter int unsigned ANIM_DIV = 4,
  parameter int unsigned STEP     = 1,
  parameter int unsigned START_X  = 10,
  parameter int unsigned START_Y  = 10,
  parameter int unsigned X_MAX    = 310,
  parameter int unsigned Y_MAX    = 230
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       respawn,
  output logic [8:0] player_x,
  output logic [8:0] player_y,
  output logic [3:0] player_state,
  output logic       moving
);

  localparam int unsigned TW = $clog2(MOVE_DIV + 1);
  localparam int unsigned AW = $clog2(ANIM_DIV + 1);

  localparam logic [TW-1:0] TickLast = TW'(MOVE_DIV - 1);
  localparam logic [AW-1:0] AnimWrap = AW'(ANIM_DIV);
  localparam logic [9:0]    Step10   = 10'(STEP);
  localparam logic [9:0]    XMax10   = 10'(X_MAX);
  localparam logic [9:0]    YMax10   = 10'(Y_MAX);
  localparam logic [8:0]    StartX   = 9'(START_X);
  localparam logic [8:0]    StartY   = 9'(START_Y);

  typedef enum logic [1:0] {StFrozen, StIdle, StWalk} fsm_e;

  fsm_e          fsm_q;
  logic [3:0]    prev_state_q;
  logic [TW-1:0] tick_cnt_q;
  logic [AW-1:0] anim_cnt_q;
  logic [8:0]    x_q, y_q;
  logic [1:0]    dir_q, frame_q;
  logic          moving_q;

  logic          is_stage, entry, tick, key_any;
  logic [9:0]    x10, y10, nx, ny;
  logic [1:0]    ndir, nframe;
  logic [AW-1:0] anim_inc, nanim;

  always_comb begin
    is_stage = (state == 4'd2) || (state == 4'd4) || (state == 4'd6);
    entry    = is_stage && (state != prev_state_q);
    tick     = (tick_cnt_q == TickLast);
    key_any  = key_up | key_down | key_left | key_right;

    x10  = {1'b0, x_q};
    y10  = {1'b0, y_q};
    nx   = x10;
    ny   = y10;
    ndir = dir_q;
    // Priority up > down > left > right; only one axis moves per tick.
    if (key_up) begin
      ndir = 2'd1;
      ny   = (y10 < Step10) ? 10'd0 : y10 - Step10;
    end else if (key_down) begin
      ndir = 2'd0;
      ny   = (y10 + Step10 > YMax10) ? YMax10 : y10 + Step10;
    end else if (key_left) begin
      ndir = 2'd2;
      nx   = (x10 < Step10) ? 10'd0 : x10 - Step10;
    end else if (key_right) begin
      ndir = 2'd3;
      nx   = (x10 + Step10 > XMax10) ? XMax10 : x10 + Step10;
    end

    anim_inc = anim_cnt_q + AW'(1);
    if (fsm_q == StIdle) begin
      nframe = 2'd1;
      nanim  = '0;
    end else if (anim_inc == AnimWrap) begin
      nframe = (frame_q == 2'd3) ? 2'd1 : frame_q + 2'd1;
      nanim  = '0;
    end else begin
      nframe = frame_q;
      nanim  = anim_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= StFrozen;
      prev_state_q <= 4'd0;
      tick_cnt_q   <= '0;
      anim_cnt_q   <= '0;
      x_q          <= StartX;
      y_q          <= StartY;
      dir_q        <= 2'd0;
      frame_q      <= 2'd0;
      moving_q     <= 1'b0;
    end else begin
      prev_state_q <= state;
      if (!is_stage) begin
        fsm_q      <= StFrozen;
        moving_q   <= 1'b0;
        tick_cnt_q <= '0;
        anim_cnt_q <= '0;
        frame_q    <= 2'd0;
      end else if (entry || (fsm_q != StFrozen && respawn)) begin
        fsm_q      <= StIdle;
        moving_q   <= 1'b0;
        tick_cnt_q <= '0;
        anim_cnt_q <= '0;
        x_q        <= StartX;
        y_q        <= StartY;
        dir_q      <= 2'd0;
        frame_q    <= 2'd0;
      end else if (fsm_q != StFrozen) begin
        if (tick) begin
          tick_cnt_q <= '0;
          if (key_any) begin
            fsm_q      <= StWalk;
            moving_q   <= 1'b1;
            x_q        <= nx[8:0];
            y_q        <= ny[8:0];
            dir_q      <= ndir;
            frame_q    <= nframe;
            anim_cnt_q <= nanim;
          end else begin
            fsm_q      <= StIdle;
            moving_q   <= 1'b0;
            frame_q    <= 2'd0;
            anim_cnt_q <= '0;
          end
        end else begin
          tick_cnt_q <= tick_cnt_q + TW'(1);
        end
      end
    end
  end

  assign player_x     = x_q;
  assign player_y     = y_q;
  assign player_state = {dir_q, frame_q};
  assign moving       = moving_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed scenarios plus random key/state traffic, all compared
// each cycle against a tick-level behavioural model of the player.
module tb_player_ctrl;

  localparam int MOVE_DIV = 4;
  localparam int ANIM_DIV = 2;
  localparam int STEP     = 1;
  localparam int START_X  = 10;
  localparam int START_Y  = 10;
  localparam int X_MAX    = 310;
  localparam int Y_MAX    = 230;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state = 4'd0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       respawn = 1'b0;
  logic [8:0] player_x, player_y;
  logic [3:0] player_state;
  logic       moving;

  player_ctrl #(
    .MOVE_DIV(MOVE_DIV), .ANIM_DIV(ANIM_DIV), .STEP(STEP), .START_X(START_X),
    .START_Y(START_Y), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .key_up(key_up), .key_down(key_down),
    .key_left(key_left), .key_right(key_right), .respawn(respawn),
    .player_x(player_x), .player_y(player_y), .player_state(player_state), .moving(moving)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = frozen, 1 = standing, 2 = walking.
  int m_x, m_y, m_dir, m_frame, m_mode, m_cyc, m_steps, m_prev;

  task automatic model_reset();
    m_x = START_X; m_y = START_Y; m_dir = 0; m_frame = 0;
    m_mode = 0; m_cyc = 0; m_steps = 0; m_prev = 0;
  endtask

  task automatic model_spawn();
    m_x = START_X; m_y = START_Y; m_dir = 0; m_frame = 0;
    m_mode = 1; m_cyc = 0; m_steps = 0;
  endtask

  task automatic model_tick();
    bit moved = 1'b1;
    if (key_up)         begin m_dir = 1; m_y = (m_y - STEP < 0) ? 0 : m_y - STEP; end
    else if (key_down)  begin m_dir = 0; m_y = (m_y + STEP > Y_MAX) ? Y_MAX : m_y + STEP; end
    else if (key_left)  begin m_dir = 2; m_x = (m_x - STEP < 0) ? 0 : m_x - STEP; end
    else if (key_right) begin m_dir = 3; m_x = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP; end
    else moved = 1'b0;
    if (!moved) begin
      m_mode = 1; m_frame = 0; m_steps = 0;
    end else if (m_mode == 1) begin
      m_mode = 2; m_frame = 1; m_steps = 0;
    end else begin
      m_steps++;
      if (m_steps == ANIM_DIV) begin
        m_steps = 0;
        m_frame = (m_frame % 3) + 1;
      end
    end
  endtask

  task automatic model_step();
    int  st = int'(state);
    bit  stage = (st == 2) || (st == 4) || (st == 6);
    bit  entry = stage && (st != m_prev);
    m_prev = st;
    if (!stage) begin
      m_mode = 0; m_cyc = 0; m_steps = 0; m_frame = 0;
    end else if (entry || (m_mode != 0 && respawn)) begin
      model_spawn();
    end else if (m_mode != 0) begin
      m_cyc++;
      if (m_cyc == MOVE_DIV) begin
        m_cyc = 0;
        model_tick();
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".x"}, int'(player_x), m_x);
    check_eq({tag, ".y"}, int'(player_y), m_y);
    check_eq({tag, ".pstate"}, int'(player_state), m_dir * 4 + m_frame);
    check_eq({tag, ".moving"}, int'(moving), (m_mode == 2) ? 1 : 0);
  endtask

  // Called just after a falling edge: apply inputs, advance model across the next rising
  // edge, then compare on the following falling edge.
  task automatic cyc(input int st, input bit u, input bit d, input bit l, input bit r,
                     input bit rsp, input string tag);
    state = st[3:0]; key_up = u; key_down = d; key_left = l; key_right = r; respawn = rsp;
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  int frame_seq[8] = '{1, 1, 2, 2, 3, 3, 1, 1};

  initial begin
    int st_cur;
    logic [3:0] keys;
    bit rsp;

    model_reset();
    @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, "title");
    cyc(0, 0, 0, 0, 0, 0, "title");

    cyc(2, 0, 0, 0, 0, 0, "entry");
    check_eq("entry_x", int'(player_x), 10);
    check_eq("entry_y", int'(player_y), 10);
    check_eq("entry_pstate", int'(player_state), 0);
    check_eq("entry_moving", int'(moving), 0);
    for (int i = 0; i < 3; i++) cyc(2, 0, 0, 0, 0, 0, "settle");
    check_eq("no_early_move_x", int'(player_x), 10);

    // One spare idle tick puts the tick phase on the 4th call of each group.
    cyc(2, 0, 0, 0, 0, 0, "idle_tick");
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < MOVE_DIV; c++) cyc(2, 0, 0, 0, 1, 0, "walk_right");
      check_eq("right_x", int'(player_x), 11 + t);
      check_eq("right_frame", int'(player_state[1:0]), frame_seq[t]);
      check_eq("right_dir", int'(player_state[3:2]), 3);
      check_eq("right_moving", int'(moving), 1);
    end
    for (int c = 0; c < MOVE_DIV; c++) cyc(2, 0, 0, 0, 0, 0, "release");
    check_eq("release_frame", int'(player_state[1:0]), 0);
    check_eq("release_moving", int'(moving), 0);
    check_eq("release_x", int'(player_x), 18);

    cyc(2, 0, 0, 0, 0, 1, "respawn");
    for (int t = 0; t < 9; t++)
      for (int c = 0; c < MOVE_DIV; c++) cyc(2, 0, 0, 1, 0, 0, "to_left_wall");
    check_eq("left_at1", int'(player_x), 1);
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < MOVE_DIV; c++) cyc(2, 0, 0, 1, 0, 0, "left_wall");
      check_eq("left_clamp_x", int'(player_x), 0);
      check_eq("left_dir", int'(player_state[3:2]), 2);
      check_eq("left_moving", int'(moving), 1);
    end

    cyc(2, 0, 0, 0, 0, 1, "respawn2");
    for (int t = 0; t < 219; t++)
      for (int c = 0; c < MOVE_DIV; c++) cyc(2, 0, 1, 0, 0, 0, "to_bottom");
    check_eq("down_at229", int'(player_y), 229);
    for (int t = 0; t < 2; t++) begin
      for (int c = 0; c < MOVE_DIV; c++) cyc(2, 0, 1, 0, 0, 0, "bottom");
      check_eq("down_clamp_y", int'(player_y), 230);
    end

    for (int c = 0; c < MOVE_DIV; c++) cyc(2, 1, 0, 0, 1, 0, "up_right");
    check_eq("upright_y", int'(player_y), 229);
    check_eq("upright_x", int'(player_x), 10);
    check_eq("upright_dir", int'(player_state[3:2]), 1);

    for (int c = 0; c < MOVE_DIV - 1; c++) cyc(2, 1, 0, 0, 0, 0, "pre_respawn");
    cyc(2, 1, 0, 0, 0, 1, "respawn_on_tick");
    check_eq("rsp_tick_x", int'(player_x), 10);
    check_eq("rsp_tick_y", int'(player_y), 10);
    check_eq("rsp_tick_pstate", int'(player_state), 0);
    check_eq("rsp_tick_moving", int'(moving), 0);

    for (int t = 0; t < 3; t++)
      for (int c = 0; c < MOVE_DIV; c++) cyc(2, 0, 0, 0, 1, 0, "walk_again");
    for (int c = 0; c < 8; c++) cyc(8, 0, 0, 0, 1, 0, "fail_frozen");
    check_eq("frozen_x", int'(player_x), 13);
    check_eq("frozen_frame", int'(player_state[1:0]), 0);
    check_eq("frozen_moving", int'(moving), 0);

    cyc(2, 0, 0, 0, 0, 0, "reentry");
    for (int c = 0; c < 10; c++) cyc(2, 0, 0, 0, 1, 0, "walk_pre_reset");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    check_eq("async_reset_x", int'(player_x), 10);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all("reset_held");

    st_cur = 2;
    keys = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0)
        st_cur = ($urandom_range(3) == 0) ? int'($urandom_range(8)) : 2 * int'($urandom_range(3, 1));
      if ($urandom_range(7) == 0) keys = 4'($urandom_range(15));
      rsp = ($urandom_range(99) == 0);
      cyc(st_cur, keys[0], keys[1], keys[2], keys[3], rsp, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
